song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//  Table-driven melody player, the successor to the hard-coded per-song FSMs.
//  Plays a song held in an internal writable note RAM. Each entry gives a pitch code, a duration code and an end flag.
//  Generates the square-wave tone internally from a pitch table.
//  Adds stop, loop mode, progress outputs and a done pulse.
//  Sits between the button debouncers and the speaker/PWM output stage.
// PARAMETERS
//  CLK_FREQ   100_000_000  clock frequency in Hz; scales the pitch table
//  DEPTH      32           note RAM entries; power of 2, >=2
//  UNIT_CYC   20_000_000   cycles per duration unit (200 ms)
//  BREAK_CYC  10_000_000   silent gap after every note (100 ms)
//  OUT_W      8            width of tune output
// PORTS
//  clk_100MHz  in   1              system clock, rising edge
//  rst_n       in   1              asynchronous active-low reset
//  play        in   1              start request; level sampled each clock
//  stop        in   1              abort playback
//  loop        in   1              1 = restart at entry 0 after the last note
//  wr_en       in   1              note RAM write strobe
//  wr_addr     in   $clog2(DEPTH)  write address
//  wr_data     in   7              {end, dur[1:0], pitch[3:0]}
//  tune        out  OUT_W          speaker drive: all-ones or all-zeros
//  busy        out  1              1 while in NOTE or BREAK
//  note_idx    out  $clog2(DEPTH)  address of the entry being played
//  done        out  1              one-cycle pulse at natural end of a non-loop song
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; tune=0, busy=0, note_idx=0, done=0; all counters 0.
//   - RAM contents are not reset.
//  FSM states: IDLE, NOTE, BREAK.
//   - IDLE -> NOTE: play=1 and stop=0. Load idx=0; clear duration and tone counters.
//   - NOTE: lasts exactly (dur+1)*UNIT_CYC cycles, then goes to BREAK.
//   - BREAK: lasts exactly BREAK_CYC cycles; tune=0 throughout. On exit:
//     - end=1, or idx==DEPTH-1: the song is over.
//       - loop=1: go to NOTE with idx=0.
//       - loop=0: go to IDLE and pulse done for 1 cycle.
//     - Otherwise go to NOTE with idx+1.
//     - Loop is sampled on the BREAK exit cycle only.
//  stop=1 in any state: IDLE on the next edge, tune=0, no done pulse.
//   - stop has priority over play and over the end-of-song transitions.
//   - play while busy is ignored. Holding play in IDLE restarts the song immediately after done.
//  Tone generation:
//   - pitch 0 = rest (tune=0 for the whole NOTE).
//   - pitch 1..15 = 262,277,294,311,330,349,370,392,415,440,466,494,554,588,660 Hz.
//   - HP[p] = CLK_FREQ/(2*f), truncated, minimum 1.
//   - Phase starts at 0 on NOTE entry and toggles every HP[p] cycles.
//   - tune = phase ? {OUT_W{1'b1}} : 0, registered.
//   - First rising edge of tune comes HP[p] cycles after NOTE entry.
//  Timing: play sampled at edge k; busy=1 and NOTE active from edge k+1.
//  note_idx is valid while busy and holds its last value in IDLE.
//  RAM writes:
//   - Accepted only while state==IDLE; ignored while busy.
//   - Write then play in the next cycle is legal; the new data is used.
//  Duration counter width: ceil(log2(4*UNIT_CYC)) or more; no wrap within a note.
//  Reset mid-note: output silent at once; the song does not resume on release.
// TESTING (CLK_FREQ=8800, UNIT_CYC=10, BREAK_CYC=4, DEPTH=4)
//  1. RAM={0:p10 d0 e0, 1:p0 d1 e1}, play pulse, loop=0
//     -> NOTE 10 cycles with tune toggling every 10 cycles, BREAK 4, rest NOTE 20, BREAK 4.
//     -> done pulses exactly 38 cycles after busy rises; then IDLE.
//  2. Same RAM, loop=1 -> after entry 1's BREAK, note_idx=0 and NOTE again. No done pulse.
//     Then stop=1 -> busy=0 and tune=0 on the next edge.
//  3. All 4 entries with end=0 -> after idx 3's BREAK the song ends (DEPTH-1 rule).
//     done=1, note_idx stays 3.
//  4. play=1 and stop=1 in the same cycle in IDLE -> stays IDLE.
//     wr_en while busy -> RAM unchanged (read back by replay).
//  5. rst_n low mid-NOTE -> tune, busy and done are 0 asynchronously.
//     Releasing rst_n with play=0 -> stays IDLE.

Source files
------------

// File: rtl/song_sequencer.sv
// Table-driven melody player: plays a song from an internal writable note RAM.
// Each RAM entry is {end, dur[1:0], pitch[3:0]} and produces a square-wave tone.
//
// Ports:
//   clk_100MHz  system clock, rising edge
//   rst_n       asynchronous active-low reset
//   play        start request (level, sampled each clock while idle)
//   stop        abort playback; wins over every other transition
//   loop        restart at entry 0 after the last note (sampled at break exit)
//   wr_en       note RAM write strobe, honoured only while idle
//   wr_addr     note RAM write address
//   wr_data     {end, dur[1:0], pitch[3:0]}
//   tune        speaker drive, all-ones or all-zeros
//   busy        high while a note or its trailing break is playing
//   note_idx    address of the entry being played; holds its value when idle
//   done        one-cycle pulse when a non-looping song ends naturally
module song_sequencer #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int DEPTH     = 32,
    parameter int UNIT_CYC  = 20_000_000,
    parameter int BREAK_CYC = 10_000_000,
    parameter int OUT_W     = 8
) (
    input  logic                     clk_100MHz,
    input  logic                     rst_n,
    input  logic                     play,
    input  logic                     stop,
    input  logic                     loop,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [6:0]               wr_data,
    output logic [OUT_W-1:0]         tune,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] note_idx,
    output logic                     done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int DUR_W = $clog2(4 * UNIT_CYC) + 1;
    localparam int BRK_W = $clog2(BREAK_CYC + 1);
    localparam int HP_W  = $clog2(CLK_FREQ / 2 + 1) + 1;

    localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BREAK_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NOTE  = 2'd1;
    localparam logic [1:0] S_BREAK = 2'd2;

    // Half period in clock cycles for each pitch code; code 0 is a rest.
    function automatic logic [HP_W-1:0] half_period(input logic [3:0] p);
        int f;
        int h;
        unique case (p)
            4'd1:    f = 262;
            4'd2:    f = 277;
            4'd3:    f = 294;
            4'd4:    f = 311;
            4'd5:    f = 330;
            4'd6:    f = 349;
            4'd7:    f = 370;
            4'd8:    f = 392;
            4'd9:    f = 415;
            4'd10:   f = 440;
            4'd11:   f = 466;
            4'd12:   f = 494;
            4'd13:   f = 554;
            4'd14:   f = 588;
            4'd15:   f = 660;
            default: f = 0;
        endcase
        h = (f == 0) ? 1 : CLK_FREQ / (2 * f);
        if (h < 1) h = 1;
        return HP_W'(h);
    endfunction

    logic [6:0]       mem [DEPTH];
    logic [1:0]       state;
    logic [AW-1:0]    idx;
    logic [DUR_W-1:0] dur_cnt;
    logic [BRK_W-1:0] brk_cnt;
    logic [HP_W-1:0]  tone_cnt;
    logic             phase;

    logic [6:0]       cur;
    logic [3:0]       cur_pitch;
    logic [1:0]       cur_dur;
    logic             cur_end;
    logic [DUR_W-1:0] note_last;
    logic [HP_W-1:0]  hp_last;
    logic             last_entry;

    // RAM contents survive reset; writes are locked out during playback so
    // the entry being read stays stable.
    always_ff @(posedge clk_100MHz) begin
        if (wr_en && state == S_IDLE) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        cur        = mem[idx];
        cur_pitch  = cur[3:0];
        cur_dur    = cur[5:4];
        cur_end    = cur[6];
        hp_last    = half_period(cur_pitch) - HP_W'(1);
        last_entry = cur_end || (idx == AW'(DEPTH - 1));
        unique case (cur_dur)
            2'd0:    note_last = DUR_W'(UNIT_CYC - 1);
            2'd1:    note_last = DUR_W'(2 * UNIT_CYC - 1);
            2'd2:    note_last = DUR_W'(3 * UNIT_CYC - 1);
            default: note_last = DUR_W'(4 * UNIT_CYC - 1);
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            dur_cnt  <= '0;
            brk_cnt  <= '0;
            tone_cnt <= '0;
            phase    <= 1'b0;
            tune     <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= S_IDLE;
                dur_cnt  <= '0;
                brk_cnt  <= '0;
                tone_cnt <= '0;
                phase    <= 1'b0;
                tune     <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (play) begin
                            state    <= S_NOTE;
                            idx      <= '0;
                            dur_cnt  <= '0;
                            tone_cnt <= '0;
                            phase    <= 1'b0;
                            tune     <= '0;
                        end
                    end
                    S_NOTE: begin
                        if (dur_cnt == note_last) begin
                            // Exit edge silences the output even if a
                            // toggle would land on this same cycle.
                            state    <= S_BREAK;
                            dur_cnt  <= '0;
                            brk_cnt  <= '0;
                            tone_cnt <= '0;
                            phase    <= 1'b0;
                            tune     <= '0;
                        end else begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                            if (cur_pitch != 4'd0) begin
                                if (tone_cnt == hp_last) begin
                                    tone_cnt <= '0;
                                    phase    <= ~phase;
                                    tune     <= {OUT_W{~phase}};
                                end else begin
                                    tone_cnt <= tone_cnt + HP_W'(1);
                                end
                            end
                        end
                    end
                    S_BREAK: begin
                        if (brk_cnt == BRK_LAST) begin
                            brk_cnt <= '0;
                            if (last_entry) begin
                                if (loop) begin
                                    state <= S_NOTE;
                                    idx   <= '0;
                                end else begin
                                    state <= S_IDLE;
                                    done  <= 1'b1;
                                end
                            end else begin
                                state <= S_NOTE;
                                idx   <= idx + AW'(1);
                            end
                        end else begin
                            brk_cnt <= brk_cnt + BRK_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy     = (state == S_NOTE) || (state == S_BREAK);
    assign note_idx = idx;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with small timing parameters.
// Offsets are counted in clocks from the edge where busy rises.
module tb_song_sequencer;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic       play;
    logic       stop;
    logic       loop;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [6:0] wr_data;
    logic [7:0] tune;
    logic       busy;
    logic [1:0] note_idx;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;
    int n;

    song_sequencer #(
        .CLK_FREQ (8800),
        .DEPTH    (4),
        .UNIT_CYC (10),
        .BREAK_CYC(4),
        .OUT_W    (8)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .rst_n     (rst_n),
        .play      (play),
        .stop      (stop),
        .loop      (loop),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .tune      (tune),
        .busy      (busy),
        .note_idx  (note_idx),
        .done      (done)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
        t++;
    endtask

    task automatic goto(input int target);
        while (t < target) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [6:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start();
        play = 1'b1;
        tick();
        play = 1'b0;
        t    = 0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = t;
        while (!done && cyc < 200) begin
            tick();
            cyc = t;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        play    = 1'b0;
        stop    = 1'b0;
        loop    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        #12;
        chk("rst_tune", tune, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", note_idx, 0);
        chk("rst_done", done, 0);
        @(posedge clk_100MHz);
        #1;
        rst_n = 1'b1;
        tick();

        // 1: p10 d0, then rest d1 with end flag
        wr(2'd0, 7'h0A);
        wr(2'd1, 7'h50);
        start();
        chk("t1_busy", busy, 1);
        chk("t1_idx0", note_idx, 0);
        goto(9);
        chk("t1_note_tune", tune, 0);
        goto(10);
        chk("t1_brk_busy", busy, 1);
        goto(14);
        chk("t1_idx1", note_idx, 1);
        wait_done(n);
        chk("t1_done_lat", n, 38);
        chk("t1_idle", busy, 0);
        chk("t1_idx_hold", note_idx, 1);
        tick();
        chk("t1_done_pulse", done, 0);

        // 2: loop mode, then stop
        loop = 1'b1;
        start();
        goto(37);
        chk("t2_pre_loop", note_idx, 1);
        goto(38);
        chk("t2_loop_idx", note_idx, 0);
        chk("t2_loop_busy", busy, 1);
        chk("t2_no_done", done, 0);
        goto(40);
        halt();
        chk("t2_stop_busy", busy, 0);
        chk("t2_stop_tune", tune, 0);
        chk("t2_stop_done", done, 0);
        loop = 1'b0;

        // 3: no end flags, tones of various pitches
        wr(2'd0, 7'h1A);
        wr(2'd1, 7'h0F);
        wr(2'd2, 7'h01);
        wr(2'd3, 7'h00);
        start();
        goto(9);
        chk("t3_p10_lo", tune, 8'h00);
        goto(10);
        chk("t3_p10_hi", tune, 8'hFF);
        goto(19);
        chk("t3_p10_hold", tune, 8'hFF);
        goto(20);
        chk("t3_brk_tune", tune, 8'h00);
        goto(29);
        chk("t3_p15_lo", tune, 8'h00);
        goto(30);
        chk("t3_p15_hi", tune, 8'hFF);
        chk("t3_idx1", note_idx, 1);
        goto(47);
        chk("t3_p1_silent", tune, 8'h00);
        goto(52);
        chk("t3_idx3", note_idx, 3);
        wait_done(n);
        chk("t3_done_lat", n, 66);
        chk("t3_done", done, 1);
        tick();
        tick();
        chk("t3_idx_hold", note_idx, 3);

        // 4: play+stop together, write while busy
        play = 1'b1;
        stop = 1'b1;
        tick();
        play = 1'b0;
        stop = 1'b0;
        chk("t4_ps_idle", busy, 0);
        tick();
        chk("t4_ps_idle2", busy, 0);
        start();
        goto(5);
        wr(2'd0, 7'h50);
        goto(8);
        halt();
        start();
        goto(10);
        chk("t4_ram_kept", tune, 8'hFF);
        halt();

        // write then play next cycle uses new data
        wr(2'd0, 7'h0F);
        start();
        goto(6);
        chk("t4_new_data", tune, 8'hFF);

        // 5: async reset mid-note
        goto(7);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tune", tune, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t5_stay_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
